// File: rtl/phy_tx_cond.sv
// Two-channel transmit PHY: per-channel FIFOs, merge, two-lane byte striping and MSB-first serialisation.
// Optional status outputs (tx_active, tx_byte_cnt) are enabled by defining PHY_TX_STATUS_EN.
module phy_tx_cond #(
  parameter int         DEPTH       = 4,
  parameter int         SYNC_FRAMES = 4,
  parameter logic [7:0] IDLE_BYTE   = 8'hBC
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic [7:0] data_in_c_0,
  input  logic       valid_in_c_0,
  output logic       ready_out_c_0,
  input  logic [7:0] data_in_c_1,
  input  logic       valid_in_c_1,
  output logic       ready_out_c_1,
  output logic       data_out_c_0,
  output logic       data_out_c_1
`ifdef PHY_TX_STATUS_EN
  ,
  output logic       tx_active,
  output logic [7:0] tx_byte_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(SYNC_FRAMES + 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {SYNC, ACTIVE} state_t;

  logic [1:0][7:0] in_data;
  logic [1:0]      in_valid;
  logic [1:0]      in_ready;
  logic [1:0]      empty;
  logic [1:0]      pop;
  logic [1:0][7:0] head;

  assign in_data  = {data_in_c_1, data_in_c_0};
  assign in_valid = {valid_in_c_1, valid_in_c_0};
  assign ready_out_c_0 = in_ready[0];
  assign ready_out_c_1 = in_ready[1];

  // Head-of-queue is read combinationally so the pop decision and the frame byte share one load edge.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [7:0]    mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg;
      logic [AW-1:0] rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic          push;

      assign in_ready[gi] = !reset && (count_reg != FULL_CNT);
      assign push         = in_valid[gi] && in_ready[gi];
      assign empty[gi]    = (count_reg == '0);
      assign head[gi]     = mem[rd_ptr_reg];

      always_ff @(posedge clk_8f) begin
        if (push) mem[wr_ptr_reg] <= in_data[gi];
      end

      always_ff @(posedge clk_8f) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi]) rd_ptr_reg <= rd_ptr_reg + 1'b1;
          case ({push, pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  state_t          state_reg, state_next;
  logic [2:0]      bit_cnt_reg;
  logic [FW-1:0]   frame_cnt_reg, frame_cnt_next;
  logic            stripe_reg, stripe_next;
  logic [1:0][7:0] shift_reg;
  logic [1:0][7:0] lane_byte;
  logic            load;

  assign load = (bit_cnt_reg == 3'd7);

  always_comb begin
    state_next     = state_reg;
    frame_cnt_next = frame_cnt_reg;
    stripe_next    = stripe_reg;
    lane_byte      = {IDLE_BYTE, IDLE_BYTE};
    pop            = '0;
    if (load) begin
      case (state_reg)
        SYNC: begin
          frame_cnt_next = frame_cnt_reg + 1'b1;
          if (frame_cnt_next == FW'(SYNC_FRAMES)) state_next = ACTIVE;
        end
        ACTIVE: begin
          pop = ~empty;
          // With two bytes the pointer toggles twice, so it ends where it started.
          case (pop)
            2'b11: begin
              lane_byte[stripe_reg]  = head[0];
              lane_byte[~stripe_reg] = head[1];
            end
            2'b01: begin
              lane_byte[stripe_reg] = head[0];
              stripe_next           = ~stripe_reg;
            end
            2'b10: begin
              lane_byte[stripe_reg] = head[1];
              stripe_next           = ~stripe_reg;
            end
            default: ;
          endcase
        end
        default: state_next = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_reg     <= SYNC;
      bit_cnt_reg   <= '0;
      frame_cnt_reg <= '0;
      stripe_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_reg + 1'b1;
      frame_cnt_reg <= frame_cnt_next;
      stripe_reg    <= stripe_next;
    end
  end

  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      always_ff @(posedge clk_8f) begin
        if (reset) shift_reg[gi] <= IDLE_BYTE;
        else if (load) shift_reg[gi] <= lane_byte[gi];
        else shift_reg[gi] <= {shift_reg[gi][6:0], 1'b0};
      end
    end
  endgenerate

  assign data_out_c_0 = shift_reg[0][7];
  assign data_out_c_1 = shift_reg[1][7];

`ifdef PHY_TX_STATUS_EN
  logic [7:0] byte_cnt_reg;

  always_ff @(posedge clk_8f) begin
    if (reset) byte_cnt_reg <= '0;
    else byte_cnt_reg <= byte_cnt_reg + 8'(pop[0]) + 8'(pop[1]);
  end

  assign tx_active   = (state_reg == ACTIVE);
  assign tx_byte_cnt = byte_cnt_reg;
`endif

endmodule
